// File: rtl/beamformer_pkg.sv
// Shared definitions for the beamformer controller and the brambeamformer core:
// slice-phase constants, the top-level sequencing states and default widths.
package beamformer_pkg;

    localparam int BF_ADDR_W   = 11;
    localparam int BF_SAMPLE_W = 16;

    typedef logic [1:0] slice_t;

    localparam slice_t SLICE_IDLE_DELAY = 2'd0;
    localparam slice_t SLICE1           = 2'd1;
    localparam slice_t SLICE2           = 2'd2;
    localparam slice_t SLICE3           = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        BEAMFORM  = 2'd2,
        READOUT   = 2'd3
    } bf_state_t;

    // Slice phases rotate 0,1,2,3,0,... one per clock while beamforming.
    function automatic slice_t next_slice(input slice_t s);
        return s + 2'd1;
    endfunction

endpackage

// File: rtl/beamformer_controller_if.sv
// Control bus between the sequencing controller (master) and brambeamformer (slave).
interface beamformer_controller_if import beamformer_pkg::*; #(
    parameter int ADDR_W   = BF_ADDR_W,
    parameter int SAMPLE_W = BF_SAMPLE_W
);

    logic                startbeamformer;
    logic                readinen;
    logic                sumouten;
    logic [ADDR_W-1:0]   readin_address;
    logic [ADDR_W-1:0]   sumout_address;
    logic [SAMPLE_W-1:0] sample_index;
    slice_t              slice_state;
    logic                usedataflag;

    modport master (
        output startbeamformer,
        output readinen,
        output sumouten,
        output readin_address,
        output sumout_address,
        output sample_index,
        output slice_state,
        input  usedataflag
    );

    modport slave (
        input  startbeamformer,
        input  readinen,
        input  sumouten,
        input  readin_address,
        input  sumout_address,
        input  sample_index,
        input  slice_state,
        output usedataflag
    );

endinterface

// File: rtl/beamformer_controller_readout_pacer.sv
// Sum-buffer address generator. Holds each address for READOUT_DIV clocks while
// running and pulses strobe on the last clock of each hold. Outside the paced
// drain the address can be cleared, or bumped by one per event.
module bf_readout_pacer #(
    parameter int ADDR_W      = 11,
    parameter int OUT_DEPTH   = 2048,
    parameter int READOUT_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,      // address/hold to 0, no strobe
    input  logic              load,     // address/hold to 0, paced drain starts next cycle
    input  logic              run,      // paced drain active this cycle
    input  logic              bump,     // unpaced +1 (ignored while clr/load/run)
    output logic [ADDR_W-1:0] addr,
    output logic              strobe,
    output logic              last      // current cycle ends the hold of the final address
);

    localparam int HOLD_W = (READOUT_DIV > 1) ? $clog2(READOUT_DIV) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(READOUT_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(OUT_DEPTH - 1);
    // With a one-clock hold every drain cycle is a strobe cycle.
    localparam logic DIV_ONE = (READOUT_DIV == 1);

    logic [HOLD_W-1:0] hold_q;
    logic              hold_end;

    assign hold_end = (hold_q == HOLD_LAST);
    assign last     = hold_end && (addr == ADDR_LAST);

    // Hold counter, address and registered strobe; strobe is precomputed so it
    // is high exactly during the final clock of each hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= '0;
            hold_q <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (clr) begin
                addr   <= '0;
                hold_q <= '0;
            end else if (load) begin
                addr   <= '0;
                hold_q <= '0;
                strobe <= DIV_ONE;
            end else if (run) begin
                if (hold_end) begin
                    hold_q <= '0;
                    if (addr != ADDR_LAST) begin
                        addr   <= addr + ADDR_W'(1);
                        strobe <= DIV_ONE;
                    end
                end else begin
                    hold_q <= hold_q + HOLD_W'(1);
                    strobe <= ((hold_q + HOLD_W'(1)) == HOLD_LAST);
                end
            end else if (bump) begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/beamformer_controller.sv
// Sequencing controller for brambeamformer: per start pulse it waits for the
// BRAMs to load, runs the slice-cycled beamforming pass over every read-in
// address, then drains the summed buffer at a paced rate.
module beamformer_controller import beamformer_pkg::*; #(
    parameter int ADDR_W      = BF_ADDR_W,
    parameter int SAMPLE_W    = BF_SAMPLE_W,
    parameter int NUM_SAMPLES = 2048,
    parameter int OUT_DEPTH   = 2048,
    parameter int LOAD_DELAY  = 10,     // must be >= 1
    parameter int SAMPLE_INIT = -2,
    parameter int READOUT_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    beamformer_controller_if.master bus,
    output logic                    out_strobe,
    output logic                    busy,
    output logic                    done
);

    localparam int LOAD_W = (LOAD_DELAY > 1) ? $clog2(LOAD_DELAY) : 1;
    localparam logic [LOAD_W-1:0]   LOAD_LAST   = LOAD_W'(LOAD_DELAY - 1);
    localparam logic [ADDR_W-1:0]   READIN_LAST = ADDR_W'(NUM_SAMPLES - 1);
    // Starting below zero lines sample_index up with the 2-cycle BRAM read latency.
    localparam logic [SAMPLE_W-1:0] SAMPLE_RST  = SAMPLE_W'(SAMPLE_INIT);

    bf_state_t           state_q, state_d;
    logic                startbf_q, startbf_d;
    logic                readinen_q, readinen_d;
    logic                sumouten_q, sumouten_d;
    slice_t              slice_q, slice_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic [ADDR_W-1:0]   readin_q, readin_d;
    logic [LOAD_W-1:0]   load_cnt_q, load_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                flag_q;

    logic                p_clr, p_load, p_run, p_bump, p_last;
    logic [ADDR_W-1:0]   p_addr;
    logic                p_strobe;

    bf_readout_pacer #(
        .ADDR_W      (ADDR_W),
        .OUT_DEPTH   (OUT_DEPTH),
        .READOUT_DIV (READOUT_DIV)
    ) u_pacer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (p_clr),
        .load   (p_load),
        .run    (p_run),
        .bump   (p_bump),
        .addr   (p_addr),
        .strobe (p_strobe),
        .last   (p_last)
    );

    // State register and registered outputs; usedataflag is sampled every
    // clock so its falling edge is seen as flag_q=1 with the live input at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            startbf_q  <= 1'b0;
            readinen_q <= 1'b0;
            sumouten_q <= 1'b0;
            slice_q    <= SLICE_IDLE_DELAY;
            sample_q   <= SAMPLE_RST;
            readin_q   <= '0;
            load_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            startbf_q  <= startbf_d;
            readinen_q <= readinen_d;
            sumouten_q <= sumouten_d;
            slice_q    <= slice_d;
            sample_q   <= sample_d;
            readin_q   <= readin_d;
            load_cnt_q <= load_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            flag_q     <= bus.usedataflag;
        end
    end

    // Next state and next output values; abort outside IDLE overrides every
    // state and leaves addresses and sample_index where they were.
    always_comb begin
        state_d    = state_q;
        startbf_d  = 1'b0;
        readinen_d = 1'b0;
        sumouten_d = 1'b0;
        slice_d    = SLICE_IDLE_DELAY;
        sample_d   = sample_q;
        readin_d   = readin_q;
        load_cnt_d = load_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        p_clr      = 1'b0;
        p_load     = 1'b0;
        p_run      = 1'b0;
        p_bump     = 1'b0;

        if (state_q != IDLE && abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_d = 1'b0;
                    if (start && !abort) begin
                        state_d    = LOAD_WAIT;
                        busy_d     = 1'b1;
                        load_cnt_d = '0;
                        sample_d   = SAMPLE_RST;
                        readin_d   = '0;
                        p_clr      = 1'b1;
                    end
                end
                LOAD_WAIT: begin
                    busy_d = 1'b1;
                    if (load_cnt_q == LOAD_LAST) begin
                        state_d    = BEAMFORM;
                        startbf_d  = 1'b1;
                        readinen_d = 1'b1;
                    end else begin
                        load_cnt_d = load_cnt_q + LOAD_W'(1);
                    end
                end
                BEAMFORM: begin
                    busy_d     = 1'b1;
                    startbf_d  = 1'b1;
                    readinen_d = 1'b1;
                    slice_d    = next_slice(slice_q);
                    p_bump     = flag_q && !bus.usedataflag;
                    if (slice_q != SLICE_IDLE_DELAY)
                        sample_d = sample_q + SAMPLE_W'(1);
                    if (slice_q == SLICE3) begin
                        if (readin_q == READIN_LAST) begin
                            state_d    = READOUT;
                            readin_d   = '0;
                            slice_d    = SLICE_IDLE_DELAY;
                            startbf_d  = 1'b0;
                            readinen_d = 1'b0;
                            sumouten_d = 1'b1;
                            p_load     = 1'b1;
                        end else begin
                            readin_d = readin_q + ADDR_W'(1);
                        end
                    end
                end
                READOUT: begin
                    busy_d     = 1'b1;
                    sumouten_d = 1'b1;
                    p_run      = 1'b1;
                    if (p_last) begin
                        state_d    = IDLE;
                        sumouten_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign bus.startbeamformer = startbf_q;
    assign bus.readinen        = readinen_q;
    assign bus.sumouten        = sumouten_q;
    assign bus.readin_address  = readin_q;
    assign bus.sumout_address  = p_addr;
    assign bus.sample_index    = sample_q;
    assign bus.slice_state     = slice_q;
    assign out_strobe          = p_strobe;
    assign busy                = busy_q;
    assign done                = done_q;

endmodule

// File: tb/tb_beamformer_controller.sv
// Bench for beamformer_controller with a small configuration (4 samples,
// 4 outputs, 10-cycle load wait, 4-clock readout hold).
module tb_beamformer_controller;
    import beamformer_pkg::*;

    localparam int ADDR_W   = 11;
    localparam int SAMPLE_W = 16;
    localparam int NS       = 4;
    localparam int OD       = 4;
    localparam int LD       = 10;
    localparam int DIV      = 4;
    localparam int SINIT    = -2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic out_strobe, busy, done;

    beamformer_controller_if #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) bus ();

    beamformer_controller #(
        .ADDR_W      (ADDR_W),
        .SAMPLE_W    (SAMPLE_W),
        .NUM_SAMPLES (NS),
        .OUT_DEPTH   (OD),
        .LOAD_DELAY  (LD),
        .SAMPLE_INIT (SINIT),
        .READOUT_DIV (DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .bus        (bus),
        .out_strobe (out_strobe),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: outputs follow from the elapsed time since an accepted
    // start, with falling usedataflag edges counted during the beamforming window.
    bit   m_active;
    int   m_t;
    int   m_edges;
    logic m_prev;
    logic e_sbf, e_rin, e_sout, e_strobe, e_busy, e_done;
    int   e_slice, e_readin, e_sumout, e_sample;

    task automatic m_reset();
        m_active = 0; m_t = 0; m_edges = 0; m_prev = 1'b0;
        e_sbf = 0; e_rin = 0; e_sout = 0; e_strobe = 0; e_busy = 0; e_done = 0;
        e_slice = 0; e_readin = 0; e_sumout = 0; e_sample = SINIT;
    endtask

    task automatic m_phase();
        int b, r;
        b = m_t - (1 + LD);
        r = b - 4 * NS;
        e_sbf = 0; e_rin = 0; e_sout = 0; e_slice = 0;
        if (b < 0) begin
            e_busy = 1;
        end else if (b < 4 * NS) begin
            e_sbf = 1; e_rin = 1; e_busy = 1;
            e_slice  = b % 4;
            e_readin = b / 4;
            e_sample = SINIT + 3 * (b / 4) + (((b % 4) == 0) ? 0 : (b % 4) - 1);
            e_sumout = m_edges;
        end else if (r < DIV * OD) begin
            e_sout = 1; e_busy = 1;
            e_readin = 0;
            e_sample = SINIT + 3 * NS;
            e_sumout = r / DIV;
            e_strobe = ((r % DIV) == DIV - 1);
        end else begin
            m_active = 0;
            e_busy = 0;
            e_done = 1;
        end
    endtask

    task automatic m_step();
        logic cur;
        int   b;
        cur = bus.usedataflag;
        e_done = 0;
        e_strobe = 0;
        if (m_active) begin
            if (abort) begin
                m_active = 0;
                e_sbf = 0; e_rin = 0; e_sout = 0; e_busy = 0; e_slice = 0;
            end else begin
                b = m_t - (1 + LD);
                if (b >= 0 && b < 4 * NS && m_prev && !cur) m_edges++;
                m_t++;
                m_phase();
            end
        end else if (start && !abort) begin
            m_active = 1; m_t = 1; m_edges = 0;
            e_busy = 1; e_sample = SINIT; e_readin = 0; e_sumout = 0;
            e_sbf = 0; e_rin = 0; e_sout = 0; e_slice = 0;
        end
        m_prev = cur;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // Compare every output against the model once per cycle, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("startbeamformer", 32'(bus.startbeamformer), 32'(e_sbf));
            chk("readinen", 32'(bus.readinen), 32'(e_rin));
            chk("sumouten", 32'(bus.sumouten), 32'(e_sout));
            chk("readin_address", 32'(bus.readin_address), 32'(e_readin));
            chk("sumout_address", 32'(bus.sumout_address), 32'(e_sumout));
            chk("sample_index", 32'(bus.sample_index), 32'(e_sample) & 32'h0000FFFF);
            chk("slice_state", 32'(bus.slice_state), 32'(e_slice));
            chk("out_strobe", 32'(out_strobe), 32'(e_strobe));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
        end
    end

    int lg_sbf, lg_ro, lg_done, n_done, lg_sum26, lg_readin26, lg_sample27, lg_busy14;
    int lg_strobe[$];

    function automatic logic flag_at(input int mode, input int c);
        if (mode == 0) return (c == 12 || c == 14 || c == 16 || c == 17 || c == 18 || c == 20 || c == 22);
        if (mode == 1) return (c == 25);
        return 1'b0;
    endfunction

    // One acquisition: start in cycle 0, then per-cycle observation and stimulus.
    // mode 0 nominal, 1 start re-pulsed while busy, 2 abort in slice 2, 3 reset mid-readout.
    task automatic run_acq(input int mode, input int ncyc);
        lg_sbf = -1; lg_ro = -1; lg_done = -1; n_done = 0;
        lg_sum26 = -1; lg_readin26 = -1; lg_sample27 = -1; lg_busy14 = -1;
        lg_strobe.delete();
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (bus.startbeamformer && lg_sbf < 0) lg_sbf = c;
            if (bus.sumouten && lg_ro < 0) lg_ro = c;
            if (out_strobe) lg_strobe.push_back(c);
            if (done) begin n_done++; lg_done = c; end
            if (c == 26) begin lg_sum26 = int'(bus.sumout_address); lg_readin26 = int'(bus.readin_address); end
            if (c == 27) lg_sample27 = int'(bus.sample_index);
            if (c == 14) lg_busy14 = int'(busy);
            bus.usedataflag = flag_at(mode, c);
            if (mode == 1 && (c == 5 || c == 15 || c == 30)) start = 1'b1;
            if (mode == 2 && c == 13) begin
                chk("abort_in_slice2", 32'(bus.slice_state), 32'd2);
                abort = 1'b1;
            end
            if (mode == 3 && c == 32) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_sumouten", 32'(bus.sumouten), 32'd0);
                chk("rst_strobe", 32'(out_strobe), 32'd0);
                chk("rst_sample", 32'(bus.sample_index), 32'h0000FFFE);
                chk("rst_sumout", 32'(bus.sumout_address), 32'd0);
                chk("rst_startbf", 32'(bus.startbeamformer), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
        end
        bus.usedataflag = 1'b0;
    endtask

    initial begin
        bus.usedataflag = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sample", 32'(bus.sample_index), 32'h0000FFFE);
        chk("reset_readinen", 32'(bus.readinen), 32'd0);
        chk("reset_slice", 32'(bus.slice_state), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Nominal run with five usedataflag falling edges (one after a 3-cycle high).
        run_acq(0, 48);
        chk("nom_startbf_cycle", lg_sbf, 11);
        chk("nom_readout_cycle", lg_ro, 27);
        chk("nom_strobe_count", lg_strobe.size(), 4);
        for (int i = 0; i < lg_strobe.size() && i < 4; i++)
            chk("nom_strobe_cycle", lg_strobe[i], 30 + 4 * i);
        chk("nom_done_cycle", lg_done, 43);
        chk("nom_done_count", n_done, 1);
        chk("nom_sumout_end_bf", lg_sum26, 5);
        chk("nom_readin_end_bf", lg_readin26, 3);
        chk("nom_sample_end", lg_sample27, 10);

        // Start re-pulsed while busy; edge on the final beamform cycle.
        run_acq(1, 48);
        chk("repulse_startbf_cycle", lg_sbf, 11);
        chk("repulse_done_cycle", lg_done, 43);
        chk("repulse_done_count", n_done, 1);

        // Start and abort together in IDLE.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("start_abort_idle_late", 32'(busy), 32'd0);

        // Abort in beamforming slice 2, then a full run from reinitialised values.
        run_acq(2, 40);
        chk("abort_busy_next", lg_busy14, 0);
        chk("abort_no_done", n_done, 0);
        run_acq(0, 48);
        chk("after_abort_done_cycle", lg_done, 43);
        chk("after_abort_sumout", lg_sum26, 5);

        // Reset mid-readout, then a fresh run.
        run_acq(3, 40);
        chk("reset_no_done", n_done, 0);
        run_acq(0, 48);
        chk("after_reset_done_cycle", lg_done, 43);
        chk("after_reset_done_count", n_done, 1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
